// File: rtl/sysbus_mem_responder_if.sv
// System bus request/response signal bundle.
// The master drives requests and consumes responses; the slave does the reverse.
interface sysbus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Line-oriented memory responder: 64-byte lines, 8 beats each.
// Reads answer after a fixed latency; writes are absorbed silently.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 1024,
  parameter int READ_LATENCY   = 4
) (
  input  logic clk,
  input  logic reset,
  sysbus_mem_responder_if.slave bus
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [2:0]               beat_q, beat_d;
  logic [LW-1:0]            lat_q, lat_d;
  logic                     wr_en;
  logic [IW-1:0]            req_idx;
  logic [IW-1:0]            widx;

  logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS] = '{default: '0};

  // Line-aligned word index of the incoming address beat.
  assign req_idx = bus.bus_req[IW+2:3] & ~IW'(7);
  assign widx    = base_q + IW'(beat_q);

  assign bus.bus_reqack  = (state_q == IDLE) || (state_q == WR_DATA);
  assign bus.bus_respcyc = (state_q == RD_RESP);
  assign bus.bus_resp    = bus.bus_respcyc ? mem_q[widx] : '0;
  assign bus.bus_resptag = bus.bus_respcyc ? tag_q : '0;

  // Control state and transaction context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[widx] <= bus.bus_req;
    end
  end

  // Next-state and write-enable decode.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    tag_d   = tag_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.bus_reqcyc) begin
          base_d = req_idx;
          beat_d = '0;
          if (bus.bus_reqtag[12]) begin
            tag_d   = bus.bus_reqtag;
            lat_d   = '0;
            state_d = RD_WAIT;
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (bus.bus_reqcyc) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = IDLE;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == LW'(READ_LATENCY - 1)) begin
          beat_d  = '0;
          state_d = RD_RESP;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      RD_RESP: begin
        if (bus.bus_respack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end
endmodule
